cc3_sysctl: RTL and testbench

CC3_SYSCTL -- requirements
Module: cc3_sysctl

---
 rtl/cc3_pkg.sv | 15 +
 rtl/cc3_extmem_fsm.sv | 85 ++++++++
 rtl/cc3_sysctl.sv | 120 ++++++++++++
 tb/tb_cc3_sysctl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc3_pkg.sv
// Shared types and default address map for the CC3 system controller.
package cc3_pkg;

  typedef enum logic [1:0] {
    EXT_IDLE   = 2'd0,
    EXT_SETUP  = 2'd1,
    EXT_ACCESS = 2'd2,
    EXT_HOLD   = 2'd3
  } ext_state_e;

  localparam logic [3:0]  DEF_BIOS_PAGE  = 4'hF;
  localparam logic [3:0]  DEF_VIDEO_PAGE = 4'hE;
  localparam logic [15:0] DEF_LED_ADDR   = 16'hDFF0;

endpackage

// File: rtl/cc3_extmem_fsm.sv
// External memory strobe sequencer: SETUP -> ACCESS (WAIT_STATES+1) -> HOLD,
// one access per CPU bus cycle, with a read latch for the returned byte.
module cc3_extmem_fsm
  import cc3_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       req,
  input  logic       wr_req,
  input  logic       cpu_ce,
  input  logic [7:0] ext_data_i,
  output logic       idle,
  output logic       cen_n,
  output logic       oen_n,
  output logic       wen_n,
  output logic       data_oe,
  output logic [7:0] rd_data
);

  ext_state_e state, state_nxt;
  logic [3:0] wait_cnt;
  logic       is_write;
  logic       done;
  logic       last_access;

  assign last_access = (wait_cnt == 4'(WAIT_STATES));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= EXT_IDLE;
      wait_cnt <= '0;
      is_write <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == EXT_ACCESS) ? wait_cnt + 4'd1 : 4'd0;
      // Direction is frozen when the access launches; write wins over read.
      if (state == EXT_IDLE) is_write <= wr_req;
      if (state == EXT_ACCESS && last_access && !is_write) rd_data <= ext_data_i;
      // done blocks a second access until the CPU finishes its bus cycle.
      if (state == EXT_ACCESS && last_access) done <= 1'b1;
      else if (cpu_ce)                        done <= 1'b0;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    cen_n     = 1'b1;
    oen_n     = 1'b1;
    wen_n     = 1'b1;
    data_oe   = 1'b0;
    case (state)
      EXT_IDLE: begin
        idle = 1'b1;
        if (req && !done) state_nxt = EXT_SETUP;
      end
      EXT_SETUP: begin
        cen_n     = 1'b0;
        data_oe   = is_write;
        state_nxt = EXT_ACCESS;
      end
      EXT_ACCESS: begin
        cen_n   = 1'b0;
        data_oe = is_write;
        oen_n   = is_write;
        wen_n   = !is_write;
        if (last_access) state_nxt = EXT_HOLD;
      end
      EXT_HOLD: begin
        cen_n     = 1'b0;
        data_oe   = is_write;
        state_nxt = EXT_IDLE;
      end
      default: state_nxt = EXT_IDLE;
    endcase
  end

endmodule

// File: rtl/cc3_sysctl.sv
// CC3 system controller: CPU clock enable, reset sequencer, address decode,
// LED/bank registers and read mux. Define CC3_SYSCTL_BANK_EN for the bank register.
module cc3_sysctl
  import cc3_pkg::*;
#(
  parameter int          CLK_DIV     = 4,
  parameter int          RST_CYCLES  = 14,
  parameter int          WAIT_STATES = 1,
  parameter int          ADDR_W      = 19,
  parameter logic [3:0]  BIOS_PAGE   = DEF_BIOS_PAGE,
  parameter logic [3:0]  VIDEO_PAGE  = DEF_VIDEO_PAGE,
  parameter logic [15:0] LED_ADDR    = DEF_LED_ADDR
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  output logic              cpu_ce_o,
  output logic              cpu_reset_o,
  input  logic [15:0]       cpu_addr_i,
  input  logic              cpu_oe_i,
  input  logic              cpu_we_i,
  input  logic [7:0]        cpu_data_i,
  output logic [7:0]        cpu_data_o,
  input  logic [7:0]        bios_data_i,
  input  logic [7:0]        video_data_i,
  output logic              bios_sel_o,
  output logic              video_sel_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  input  logic [7:0]        ext_data_i,
  output logic [7:0]        ext_data_o,
  output logic              ext_data_oe_o,
  output logic              ext_cen_n_o,
  output logic              ext_oen_n_o,
  output logic              ext_wen_n_o,
  output logic [7:0]        leds_o
);

  logic [7:0] div_cnt;
  logic [7:0] rst_cnt;
  logic       div_wrap;
  logic       ext_idle;
  logic       bios_sel, video_sel, led_hit, bank_hit, io_sel, ext_sel;
  logic [7:0] bank_rd;
  logic [7:0] ext_rd;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_cnt     <= 8'd0;
      cpu_reset_o <= 1'b1;
    end else if (cpu_reset_o) begin
      if (rst_cnt == 8'(RST_CYCLES - 1)) cpu_reset_o <= 1'b0;
      else                               rst_cnt     <= rst_cnt + 8'd1;
    end
  end

  // The divider stalls during external accesses, stretching the CPU bus cycle.
  assign div_wrap = (div_cnt == 8'(CLK_DIV - 1));
  assign cpu_ce_o = div_wrap && !cpu_reset_o && ext_idle;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                      div_cnt <= 8'd0;
    else if (!cpu_reset_o && ext_idle)   div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
  end

  assign bios_sel    = (cpu_addr_i[15:12] == BIOS_PAGE);
  assign video_sel   = (cpu_addr_i[15:12] == VIDEO_PAGE);
  assign led_hit     = (cpu_addr_i == LED_ADDR);
  assign bank_hit    = (cpu_addr_i == LED_ADDR + 16'd1);
  assign io_sel      = led_hit || bank_hit;
  assign ext_sel     = !(bios_sel || video_sel || io_sel);
  assign bios_sel_o  = bios_sel;
  assign video_sel_o = video_sel;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                            leds_o <= 8'h00;
    else if (cpu_ce_o && cpu_we_i && led_hit)  leds_o <= cpu_data_i;
  end

`ifdef CC3_SYSCTL_BANK_EN
  logic [7:0] bank;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                            bank <= 8'h00;
    else if (cpu_ce_o && cpu_we_i && bank_hit) bank <= cpu_data_i;
  end

  // Truncation keeps only the bank bits that fit above the 16-bit CPU address.
  assign ext_addr_o = ADDR_W'({bank, cpu_addr_i});
  assign bank_rd    = bank;
`else
  assign ext_addr_o = ADDR_W'(cpu_addr_i);
  assign bank_rd    = 8'h00;
`endif

  assign ext_data_o = cpu_data_i;

  cc3_extmem_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_ext (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req       (ext_sel && (cpu_oe_i || cpu_we_i)),
    .wr_req    (cpu_we_i),
    .cpu_ce    (cpu_ce_o),
    .ext_data_i(ext_data_i),
    .idle      (ext_idle),
    .cen_n     (ext_cen_n_o),
    .oen_n     (ext_oen_n_o),
    .wen_n     (ext_wen_n_o),
    .data_oe   (ext_data_oe_o),
    .rd_data   (ext_rd)
  );

  always_comb begin
    cpu_data_o = ext_rd;
    if (bios_sel)       cpu_data_o = bios_data_i;
    else if (video_sel) cpu_data_o = video_data_i;
    else if (io_sel)    cpu_data_o = led_hit ? leds_o : bank_rd;
  end

endmodule

// File: tb/tb_cc3_sysctl.sv
// Self-checking bench for cc3_sysctl: directed scenarios plus randomized CPU
// bus cycles compared every clock against a transaction-level model.
module tb_cc3_sysctl;

  localparam int          CLK_DIV     = 4;
  localparam int          RST_CYCLES  = 14;
  localparam int          WAIT_STATES = 1;
  localparam int          ADDR_W      = 19;
  localparam logic [3:0]  BIOS_PAGE   = 4'hF;
  localparam logic [3:0]  VIDEO_PAGE  = 4'hE;
  localparam logic [15:0] LED_ADDR    = 16'hDFF0;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b1;
  logic              cpu_ce_o, cpu_reset_o;
  logic [15:0]       cpu_addr_i = 16'h0100;
  logic              cpu_oe_i = 1'b0, cpu_we_i = 1'b0;
  logic [7:0]        cpu_data_i = 8'h00, cpu_data_o;
  logic [7:0]        bios_data_i = 8'h00, video_data_i = 8'h00;
  logic              bios_sel_o, video_sel_o;
  logic [ADDR_W-1:0] ext_addr_o;
  logic [7:0]        ext_data_i = 8'h00, ext_data_o;
  logic              ext_data_oe_o, ext_cen_n_o, ext_oen_n_o, ext_wen_n_o;
  logic [7:0]        leds_o;

  cc3_sysctl #(
    .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .WAIT_STATES(WAIT_STATES),
    .ADDR_W(ADDR_W), .BIOS_PAGE(BIOS_PAGE), .VIDEO_PAGE(VIDEO_PAGE), .LED_ADDR(LED_ADDR)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cpu_ce_o(cpu_ce_o), .cpu_reset_o(cpu_reset_o),
    .cpu_addr_i(cpu_addr_i), .cpu_oe_i(cpu_oe_i), .cpu_we_i(cpu_we_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .bios_data_i(bios_data_i), .video_data_i(video_data_i),
    .bios_sel_o(bios_sel_o), .video_sel_o(video_sel_o),
    .ext_addr_o(ext_addr_o), .ext_data_i(ext_data_i), .ext_data_o(ext_data_o),
    .ext_data_oe_o(ext_data_oe_o), .ext_cen_n_o(ext_cen_n_o),
    .ext_oen_n_o(ext_oen_n_o), .ext_wen_n_o(ext_wen_n_o), .leds_o(leds_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state the CPU can observe.
  logic [7:0] m_leds = 8'h00;
  logic [7:0] m_bank = 8'h00;
  logic [7:0] m_latch = 8'h00;
  int         rel_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bank_readback();
`ifdef CC3_SYSCTL_BANK_EN
    return m_bank;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [23:0] full_addr(input logic [15:0] a);
`ifdef CC3_SYSCTL_BANK_EN
    return {m_bank, a};
`else
    return {8'h00, a};
`endif
  endfunction

  // One CPU bus cycle, entered just after the clock edge that starts it.
  // A launched external access stretches the cycle by SETUP+ACCESS+HOLD clocks.
  task automatic run_op(input logic [15:0] a, input logic oe, input logic we,
                        input logic [7:0] wd, input logic [7:0] xin,
                        input logic [7:0] bin, input logic [7:0] vin,
                        output int n_cen, output int n_oen, output int n_ce,
                        output int ce_cyc, output logic [7:0] rd, output logic [31:0] xa);
    logic bs, vs, io, ex, acc, busy, in_acc;
    logic [7:0] exp_rd, exp_ctl, act_ctl;
    logic [23:0] fa;
    int len;
    bs  = (a[15:12] == BIOS_PAGE);
    vs  = (a[15:12] == VIDEO_PAGE);
    io  = (a == LED_ADDR) || (a == LED_ADDR + 16'd1);
    ex  = !(bs || vs || io);
    acc = ex && (oe || we);
    len = acc ? CLK_DIV + WAIT_STATES + 3 : CLK_DIV;
    fa  = full_addr(a);
    if (bs)       exp_rd = bin;
    else if (vs)  exp_rd = vin;
    else if (io)  exp_rd = (a == LED_ADDR) ? m_leds : bank_readback();
    else          exp_rd = (acc && !we) ? xin : m_latch;
    n_cen = 0; n_oen = 0; n_ce = 0; ce_cyc = 0; rd = 8'h00; xa = 32'h0;
    for (int i = 0; i < len; i++) begin
      cpu_addr_i = a; cpu_oe_i = oe; cpu_we_i = we; cpu_data_i = wd;
      bios_data_i = bin; video_data_i = vin;
      ext_data_i = (i == WAIT_STATES + 2) ? xin : ~xin;
      @(negedge clk_i);
      busy    = acc && (i >= 1) && (i <= WAIT_STATES + 3);
      in_acc  = acc && (i >= 2) && (i <= WAIT_STATES + 2);
      exp_ctl = {(i == len - 1), 1'b0, !busy, !(in_acc && !we), !(in_acc && we),
                 busy && we, bs, vs};
      act_ctl = {cpu_ce_o, cpu_reset_o, ext_cen_n_o, ext_oen_n_o, ext_wen_n_o,
                 ext_data_oe_o, bios_sel_o, video_sel_o};
      check("ctl", 32'(act_ctl), 32'(exp_ctl));
      check("ext_addr", 32'(ext_addr_o), 32'(fa[ADDR_W-1:0]));
      check("ext_wdata", 32'(ext_data_o), 32'(wd));
      check("leds", 32'(leds_o), 32'(m_leds));
      if (!ext_cen_n_o) n_cen++;
      if (!ext_oen_n_o) n_oen++;
      if (i == 1) xa = 32'(ext_addr_o);
      if (cpu_ce_o) begin
        n_ce++;
        ce_cyc = cyc;
        rd = cpu_data_o;
        check("rdata", 32'(cpu_data_o), 32'(exp_rd));
      end
      @(posedge clk_i); #1;
    end
    if (io && we) begin
      if (a == LED_ADDR) m_leds = wd;
      else               m_bank = wd;
    end
    if (acc && !we) m_latch = xin;
  endtask

  task automatic release_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    rel_cyc = cyc;
    for (int k = 0; k < RST_CYCLES; k++) begin
      @(negedge clk_i);
      check("rst_seq", 32'({cpu_ce_o, cpu_reset_o, ext_cen_n_o, ext_oen_n_o,
                            ext_wen_n_o, ext_data_oe_o}), 32'(6'b011110));
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    int n_cen, n_oen, n_ce, ce1, ce2;
    logic [7:0] rd;
    logic [31:0] xa;
    logic [15:0] a;
    logic oe, we;

    #2 reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_ctl", 32'({cpu_ce_o, cpu_reset_o, ext_cen_n_o, ext_oen_n_o,
                            ext_wen_n_o, ext_data_oe_o}), 32'(6'b011110));
    check("reset_leds", 32'(leds_o), 32'h00);
    check("reset_latch", 32'(cpu_data_o), 32'h00);
    release_reset();

    // Reset release and divider cadence.
    run_op(16'h0100, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    run_op(16'h0100, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce2, rd, xa);
    check("first_ce_delay", 32'(ce1 - rel_cyc), 32'd17);
    check("ce_period", 32'(ce2 - ce1), 32'd4);

    // External read at 0x1234.
    run_op(16'h1234, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h11, 8'h22, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("rd_cen_len", 32'(n_cen), 32'd4);
    check("rd_oen_len", 32'(n_oen), 32'd2);
    check("rd_ce_count", 32'(n_ce), 32'd1);
    check("rd_data", 32'(rd), 32'hA5);
    run_op(16'h1234, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 8'h22, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("rd_latch_hold", 32'(rd), 32'hA5);

    // LED write stays internal.
    run_op(LED_ADDR, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("led_no_cen", 32'(n_cen), 32'd0);
    check("led_value", 32'(leds_o), 32'h3C);

    // Bank register steering the upper address bits.
    run_op(LED_ADDR + 16'd1, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    run_op(16'h0010, 1'b1, 1'b0, 8'h00, 8'h6E, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
`ifdef CC3_SYSCTL_BANK_EN
    check("bank_addr", xa, 32'h50010);
`else
    check("bank_addr", xa, 32'h00010);
`endif

    // BIOS read.
    run_op(16'hF000, 1'b1, 1'b0, 8'h00, 8'h77, 8'h5A, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("bios_rd", 32'(rd), 32'h5A);
    check("bios_no_cen", 32'(n_cen), 32'd0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 16'($urandom);
        3:       a = {BIOS_PAGE, 12'($urandom)};
        4:       a = {VIDEO_PAGE, 12'($urandom)};
        5:       a = LED_ADDR;
        6:       a = LED_ADDR + 16'd1;
        default: a = {4'h0, 12'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0:       begin oe = 1'b0; we = 1'b0; end
        1:       begin oe = 1'b1; we = 1'b0; end
        2:       begin oe = 1'b0; we = 1'b1; end
        default: begin oe = 1'b1; we = 1'b1; end
      endcase
      run_op(a, oe, we, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             n_cen, n_oen, n_ce, ce1, rd, xa);
      check("op_ce_count", 32'(n_ce), 32'd1);
    end

    // Reset asserted in the middle of an external write.
    run_op(LED_ADDR, 1'b0, 1'b1, 8'hA7, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    run_op(16'h0300, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    cpu_addr_i = 16'h2000; cpu_oe_i = 1'b0; cpu_we_i = 1'b1; cpu_data_i = 8'h99;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("pre_rst_wen", 32'(ext_wen_n_o), 32'd0);
    reset_n_i = 1'b0;
    #1;
    check("rst_async", 32'({cpu_ce_o, cpu_reset_o, ext_cen_n_o, ext_oen_n_o,
                            ext_wen_n_o, ext_data_oe_o}), 32'(6'b011110));
    check("rst_async_leds", 32'(leds_o), 32'h00);
    m_leds = 8'h00; m_bank = 8'h00; m_latch = 8'h00;
    cpu_we_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("rst_hold", 32'({cpu_ce_o, cpu_reset_o, ext_cen_n_o, ext_oen_n_o,
                             ext_wen_n_o, ext_data_oe_o}), 32'(6'b011110));
    end
    release_reset();
    run_op(16'h2000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("latch_after_rst", 32'(rd), 32'h00);
    check("no_strobe_after_rst", 32'(n_cen), 32'd0);
    run_op(16'h0400, 1'b1, 1'b0, 8'h00, 8'h3D, 8'h00, 8'h00, n_cen, n_oen, n_ce, ce1, rd, xa);
    check("rd_after_rst", 32'(rd), 32'h3D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
